bpf_alu_mc: RTL and testbench
=============================

// Module: bpf_alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU for the BPF datapath. Width-generic single-cycle ops,
//  pipelined multiply, iterative radix-2 divide/modulo, divide-by-zero flag.
//  Single outstanding op with ready/valid/ack handshake. Sits between regfile A/B and writeback.
// PARAMETERS
//  W        32  operand/result width (>=8)
//  MUL_LAT  3   accept-to-valid latency of MUL in cycles (>=1); multiplier pipelined over MUL_LAT stages
//  PESS     0   1 = register A/B inputs one extra cycle before any op (adds 1 to every latency)
// PORTS
//  clk      in   1    clock
//  rst      in   1    synchronous, active-high reset
//  A        in   W    operand A
//  B        in   W    operand B
//  ALU_sel  in   4    op: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOT,6 LSH,7 RSH,8 MUL,9 DIV,10 MOD
//  ALU_en   in   1    start request; accepted only when ALU_rdy=1
//  ALU_rdy  out  1    block can accept a new op this cycle
//  ALU_out  out  W    result, stable while ALU_vld=1
//  eq/gt/ge/set out 1 each  A==B, A>B unsigned, A>=B, (A&B)!=0; from accepted operands
//  dz       out  1    DIV/MOD with B==0
//  ALU_vld  out  1    result valid; held until ALU_ack
//  ALU_ack  in   1    consumer takes result
// BEHAVIOUR
//  Reset: ALU_out=0, eq=gt=ge=set=dz=0, ALU_vld=0, ALU_rdy=1, FSM=IDLE, mul pipe valid bits cleared.
//  ALU_rdy = (state==IDLE) && (!ALU_vld || ALU_ack). Accept = ALU_en && ALU_rdy (cycle N).
//  ALU_en while !ALU_rdy is ignored, no side effects. A, B, ALU_sel latched at accept.
//  FSM: IDLE -> (sel<=7) DONE_1 | (sel==8) MUL | (sel 9/10, B!=0) DIV | (sel 9/10, B==0) DONE_1.
//   DONE_1 / MUL count done / DIV count done -> write ALU_out+flags, ALU_vld=1, return IDLE.
//  Latency (PESS=0): ops 0-7 and div-by-zero: ALU_vld at N+1; MUL: N+MUL_LAT; DIV/MOD: N+W+1.
//  Flags eq/gt/ge/set/dz update in same cycle as ALU_out, for every op; dz=0 except div-by-zero.
//  Arithmetic: all unsigned, mod 2^W. ADD/SUB wrap. MUL keeps low W bits of product.
//   LSH/RSH logical; shift amount = B unsigned, any amount >= W yields 0.
//   DIV by zero -> ALU_out = all ones; MOD by zero -> ALU_out = A; dz=1.
//   sel 11-15: treated as single-cycle, ALU_out = 0, flags still computed.
//  Divider: restoring, one quotient bit per cycle, W iterations + 1 writeback cycle.
//  ALU_vld falls cycle after ALU_ack sampled high, unless a new accept in same cycle
//   (ack+en back-to-back): old result retires, new op starts; for 1-cycle ops ALU_vld stays 1
//   and ALU_out changes to new result at N+1 (no bubble).
//  ALU_ack while ALU_vld=0: ignored. ALU_out/flags hold last result until next completion.
//  rst mid-operation (MUL or DIV): op aborted, no ALU_vld pulse, all outputs to reset values next cycle.
//  ALU_sel changing after accept has no effect on the in-flight op.
// TESTING
//  1. ADD A=5,B=7 accept at N -> ALU_vld=1 at N+1, ALU_out=12, gt=0, eq=0; held until ack.
//  2. SUB A=0,B=1 -> ALU_out=0xFFFFFFFF (W=32); LSH A=1,B=40 -> 0; RSH A=0x80000000,B=31 -> 1.
//  3. MUL A=123,B=456 (MUL_LAT=3) -> ALU_out=56088 at N+3; ALU_rdy=0 during N+1..N+2.
//  4. DIV A=100,B=7 -> 14 at N+33; MOD same operands -> 2; ALU_en during busy ignored.
//  5. DIV A=9,B=0 -> ALU_out=0xFFFFFFFF, dz=1 at N+1; MOD A=9,B=0 -> 9, dz=1.
//  6. ack+en same cycle with XOR stream -> one result per cycle, ALU_vld continuous;
//     rst asserted at N+10 of DIV -> ALU_vld never rises, ALU_rdy=1 next cycle.

Source files
------------

// File: rtl/bpf_alu_mc.sv
// Multi-cycle ALU for the BPF datapath: single-cycle logic/arith ops, pipelined multiply,
// restoring radix-2 divide/modulo, with a single-outstanding ready/valid/ack handshake.
module bpf_alu_mc #(
  parameter int W       = 32,
  parameter int MUL_LAT = 3,
  parameter int PESS    = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   ALU_sel,
  input  logic         ALU_en,
  output logic         ALU_rdy,
  output logic [W-1:0] ALU_out,
  output logic         eq,
  output logic         gt,
  output logic         ge,
  output logic         set,
  output logic         dz,
  output logic         ALU_vld,
  input  logic         ALU_ack
);

  localparam int CW = $clog2(W);
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MOD = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_MUL, S_DIV} state_t;
  state_t state, state_n;

  logic [W-1:0]  a_q, b_q;
  logic [3:0]    sel_q;
  logic          accept, launch;
  logic [W-1:0]  op_a, op_b;
  logic [3:0]    op_sel;
  logic          op_is_div;
  logic [W-1:0]  single_res, prod;
  logic          mul_start, mul_done;
  logic [W-1:0]  mul_res;
  logic [W-1:0]  rem, quo, rem_n, quo_n;
  logic [W:0]    rem_sh, rem_diff;
  logic [CW-1:0] cnt;
  logic          wr, res_dz;
  logic [W-1:0]  res, fa, fb;

  assign ALU_rdy = (state == S_IDLE) && (!ALU_vld || ALU_ack);
  assign accept  = ALU_en && ALU_rdy;

  // With PESS the op is launched from the latched copies one cycle after accept.
  assign launch    = (PESS != 0) ? (state == S_PRE) : accept;
  assign op_a      = (PESS != 0) ? a_q : A;
  assign op_b      = (PESS != 0) ? b_q : B;
  assign op_sel    = (PESS != 0) ? sel_q : ALU_sel;
  assign op_is_div = (op_sel == OP_DIV) || (op_sel == OP_MOD);
  assign prod      = op_a * op_b;
  assign mul_start = launch && (op_sel == OP_MUL);

  always_comb begin
    single_res = '0;
    case (op_sel)
      4'd0:    single_res = op_a + op_b;
      4'd1:    single_res = op_a - op_b;
      4'd2:    single_res = op_a & op_b;
      4'd3:    single_res = op_a | op_b;
      4'd4:    single_res = op_a ^ op_b;
      4'd5:    single_res = ~op_a;
      4'd6:    single_res = (op_b >= W'(W)) ? '0 : (op_a << op_b);
      4'd7:    single_res = (op_b >= W'(W)) ? '0 : (op_a >> op_b);
      OP_MUL:  single_res = prod;
      OP_DIV:  single_res = '1;
      OP_MOD:  single_res = op_a;
      default: single_res = '0;
    endcase
  end

  // The last pipeline register feeds ALU_out directly, so MUL_LAT-1 internal stages suffice.
  if (MUL_LAT == 1) begin : g_mul_comb
    assign mul_res  = prod;
    assign mul_done = mul_start;
  end else begin : g_mul_pipe
    logic [W-1:0]         mp [MUL_LAT-1];
    logic [MUL_LAT-2:0]   mv;

    always_ff @(posedge clk) begin
      if (rst) mv <= '0;
      else begin
        mv[0] <= mul_start;
        for (int i = 1; i < MUL_LAT-1; i++) mv[i] <= mv[i-1];
      end
      mp[0] <= prod;
      for (int i = 1; i < MUL_LAT-1; i++) mp[i] <= mp[i-1];
    end

    assign mul_res  = mp[MUL_LAT-2];
    assign mul_done = mv[MUL_LAT-2];
  end

  assign rem_sh   = {rem, quo[W-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};

  always_comb begin
    if (rem_sh >= {1'b0, b_q}) begin
      rem_n = rem_diff[W-1:0];
      quo_n = {quo[W-2:0], 1'b1};
    end else begin
      rem_n = rem_sh[W-1:0];
      quo_n = {quo[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    wr      = 1'b0;
    res     = single_res;
    fa      = op_a;
    fb      = op_b;
    res_dz  = 1'b0;
    case (state)
      S_IDLE: if (accept && (PESS != 0)) state_n = S_PRE;
      S_MUL: if (mul_done) begin
        wr      = 1'b1;
        res     = mul_res;
        fa      = a_q;
        fb      = b_q;
        state_n = S_IDLE;
      end
      S_DIV: if (cnt == CW'(W-1)) begin
        wr      = 1'b1;
        res     = (sel_q == OP_DIV) ? quo_n : rem_n;
        fa      = a_q;
        fb      = b_q;
        state_n = S_IDLE;
      end
      default: ;
    endcase
    // Divide-by-zero completes as a single-cycle op.
    if (launch) begin
      if ((op_sel == OP_MUL) && (MUL_LAT > 1)) state_n = S_MUL;
      else if (op_is_div && (op_b != '0))      state_n = S_DIV;
      else begin
        wr      = 1'b1;
        res     = single_res;
        res_dz  = op_is_div;
        state_n = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_out <= '0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      ge      <= 1'b0;
      set     <= 1'b0;
      dz      <= 1'b0;
      ALU_vld <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        sel_q <= ALU_sel;
      end
      if (launch && op_is_div) begin
        rem <= '0;
        quo <= op_a;
        cnt <= '0;
      end else if (state == S_DIV) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 1'b1;
      end
      // A completion in the same cycle as an ack keeps valid high with the new result.
      if (wr) begin
        ALU_out <= res;
        eq      <= (fa == fb);
        gt      <= (fa > fb);
        ge      <= (fa >= fb);
        set     <= |(fa & fb);
        dz      <= res_dz;
        ALU_vld <= 1'b1;
      end else if (ALU_ack) begin
        ALU_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bpf_alu_mc.sv
// Testbench for bpf_alu_mc: directed literal checks plus randomized traffic compared
// every cycle against a latency-countdown behavioural model.
module tb_bpf_alu_mc;

  localparam int W       = 32;
  localparam int MUL_LAT = 3;
  localparam int PESS    = 0;

  typedef struct packed {
    logic [W-1:0] out;
    logic         eq, gt, ge, set, dz;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B;
  logic [3:0]   ALU_sel;
  logic         ALU_en, ALU_ack;
  logic         ALU_rdy, ALU_vld;
  logic [W-1:0] ALU_out;
  logic         eq, gt, ge, set, dz;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  int   m_busy;
  logic m_vld;
  res_t m_cur, m_pend;
  bit   m_acc;

  always #5 clk = ~clk;

  bpf_alu_mc #(.W(W), .MUL_LAT(MUL_LAT), .PESS(PESS)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALU_sel(ALU_sel), .ALU_en(ALU_en),
    .ALU_rdy(ALU_rdy), .ALU_out(ALU_out), .eq(eq), .gt(gt), .ge(ge), .set(set),
    .dz(dz), .ALU_vld(ALU_vld), .ALU_ack(ALU_ack)
  );

  function automatic res_t refOp(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] sel);
    res_t r;
    logic [W-1:0] p;
    r = '0;
    p = a * b;
    case (sel)
      4'd0:  r.out = a + b;
      4'd1:  r.out = a - b;
      4'd2:  r.out = a & b;
      4'd3:  r.out = a | b;
      4'd4:  r.out = a ^ b;
      4'd5:  r.out = ~a;
      4'd6:  r.out = (b >= W) ? '0 : a << b;
      4'd7:  r.out = (b >= W) ? '0 : a >> b;
      4'd8:  r.out = p;
      4'd9:  r.out = (b == 0) ? '1 : a / b;
      4'd10: r.out = (b == 0) ? a : a % b;
      default: r.out = '0;
    endcase
    r.eq  = (a == b);
    r.gt  = (a > b);
    r.ge  = (a >= b);
    r.set = ((a & b) != 0);
    r.dz  = ((sel == 4'd9) || (sel == 4'd10)) && (b == 0);
    return r;
  endfunction

  function automatic int refLat(input logic [W-1:0] b, input logic [3:0] sel);
    int l;
    if (sel == 4'd8)                                   l = MUL_LAT;
    else if (((sel == 4'd9) || (sel == 4'd10)) && b != 0) l = W + 1;
    else                                               l = 1;
    return l + PESS;
  endfunction

  // Model: a pending result becomes visible after a countdown equal to its latency.
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_vld  = 1'b0;
      m_cur  = '0;
    end else begin
      m_acc = ALU_en && (m_busy == 0) && (!m_vld || ALU_ack);
      if (m_vld && ALU_ack) m_vld = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_cur = m_pend;
          m_vld = 1'b1;
        end
      end
      if (m_acc) begin
        m_pend = refOp(A, B, ALU_sel);
        m_busy = refLat(B, ALU_sel) - 1;
        if (m_busy == 0) begin
          m_cur = m_pend;
          m_vld = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    wait (chk_en);
    forever begin
      @(negedge clk);
      checkOutput("rdy", ALU_rdy, (m_busy == 0) && (!m_vld || ALU_ack));
      checkOutput("vld", ALU_vld, m_vld);
      checkOutput("out", ALU_out, m_cur.out);
      checkOutput("flags", {eq, gt, ge, set, dz},
                  {m_cur.eq, m_cur.gt, m_cur.ge, m_cur.set, m_cur.dz});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus();
    rst     = ($urandom_range(0, 299) == 0);
    ALU_en  = $urandom_range(0, 1) == 1;
    ALU_ack = $urandom_range(0, 2) != 0;
    ALU_sel = 4'($urandom_range(0, 15));
    A = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
    case ($urandom_range(0, 3))
      0:       B = '0;
      1:       B = W'($urandom_range(0, 40));
      default: B = W'($urandom);
    endcase
  endtask

  task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] sel, input logic [W-1:0] exp_out,
                       input logic exp_dz, input int exp_lat, input bit noise);
    int lat;
    A = a; B = b; ALU_sel = sel; ALU_en = 1'b1; ALU_ack = 1'b0;
    tick();
    ALU_en  = noise;
    ALU_sel = 4'd0;
    A = $urandom; B = $urandom;
    lat = 1;
    while (!ALU_vld && lat < 200) begin
      tick();
      lat++;
    end
    ALU_en = 1'b0;
    checkOutput({name, "_lat"}, W'(lat), W'(exp_lat));
    checkOutput({name, "_out"}, ALU_out, exp_out);
    checkOutput({name, "_dz"}, W'(dz), W'(exp_dz));
    tick();
    tick();
    checkOutput({name, "_hold_vld"}, W'(ALU_vld), W'(1));
    checkOutput({name, "_hold_out"}, ALU_out, exp_out);
    ALU_ack = 1'b1;
    tick();
    ALU_ack = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; ALU_en = 1'b0; ALU_ack = 1'b0; ALU_sel = '0; A = '0; B = '0;
    tick();
    chk_en = 1'b1;
    tick();
    checkOutput("reset_rdy", W'(ALU_rdy), W'(1));
    checkOutput("reset_vld", W'(ALU_vld), W'(0));
    checkOutput("reset_out", ALU_out, '0);
    checkOutput("reset_flags", W'({eq, gt, ge, set, dz}), '0);
    rst = 1'b0;
    tick();

    // Directed expectations assume the default W=32, MUL_LAT=3 parameters.
    runOp("add", 32'd5, 32'd7, 4'd0, 32'd12, 1'b0, 1 + PESS, 1'b0);
    checkOutput("add_flags", W'({eq, gt, ge, set}), W'(4'b0001));
    runOp("sub", 32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF, 1'b0, 1 + PESS, 1'b0);
    runOp("lsh", 32'd1, 32'd40, 4'd6, 32'd0, 1'b0, 1 + PESS, 1'b0);
    runOp("rsh", 32'h8000_0000, 32'd31, 4'd7, 32'd1, 1'b0, 1 + PESS, 1'b0);
    runOp("mul", 32'd123, 32'd456, 4'd8, 32'd56088, 1'b0, 3 + PESS, 1'b0);
    runOp("div", 32'd100, 32'd7, 4'd9, 32'd14, 1'b0, 33 + PESS, 1'b1);
    runOp("mod", 32'd100, 32'd7, 4'd10, 32'd2, 1'b0, 33 + PESS, 1'b1);
    runOp("div0", 32'd9, 32'd0, 4'd9, 32'hFFFF_FFFF, 1'b1, 1 + PESS, 1'b0);
    runOp("mod0", 32'd9, 32'd0, 4'd10, 32'd9, 1'b1, 1 + PESS, 1'b0);

    // Back-to-back XOR stream with ack+en every cycle.
    A = 32'hF0F0_F0F0; B = 32'hFF00_FF00; ALU_sel = 4'd4; ALU_en = 1'b1; ALU_ack = 1'b0;
    tick();
    checkOutput("xor_first", ALU_out, 32'h0FF0_0FF0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (ALU_vld) cnt++;
      ALU_ack = 1'b1;
      A = $urandom; B = $urandom;
      tick();
    end
    checkOutput("xor_stream_vld", W'(cnt), W'(8));
    ALU_en = 1'b0; ALU_ack = 1'b1;
    tick();
    ALU_ack = 1'b0;
    tick();

    // Reset in the middle of a divide.
    A = 32'd1000; B = 32'd3; ALU_sel = 4'd9; ALU_en = 1'b1;
    tick();
    ALU_en = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_rdy", W'(ALU_rdy), W'(1));
    checkOutput("abort_vld", W'(ALU_vld), W'(0));
    checkOutput("abort_out", ALU_out, '0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ALU_vld) cnt++;
      tick();
    end
    checkOutput("abort_no_vld", W'(cnt), W'(0));

    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      tick();
    end
    rst = 1'b0; ALU_en = 1'b0; ALU_ack = 1'b1;
    repeat (50) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
